router_fsm_nch: RTL and testbench

- Parametrised next-generation packet-router control FSM. Decodes the destination from the header byte and sequences header, payload and parity loads into one of NUM_CH output FIFOs.
- Adds features the 3-channel FSM lacks:
  - a latched destination, so no reliance on live header bits while waiting;
  - per-channel vectors for full, empty and soft reset;
  - an invalid-address drop path;
  - a bounded wait-till-empty timeout.
- Sits between the input synchroniser/register block and the per-channel FIFOs.

---
 rtl/router_fsm_nch_pkg.sv | 39 +++
 rtl/router_fsm_nch_if.sv | 38 +++
 rtl/router_fsm_nch.sv | 131 +++++++++++++
 tb/tb_router_fsm_nch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/router_fsm_nch_pkg.sv
// Shared types for the N-channel router control FSM: state encodings and
// a constant clog2 helper used to size the address field and wait counter.
package router_pkg;

  localparam logic [3:0] ST_DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] ST_LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] ST_LOAD_DATA          = 4'd2;
  localparam logic [3:0] ST_LOAD_PARITY        = 4'd3;
  localparam logic [3:0] ST_FIFO_FULL          = 4'd4;
  localparam logic [3:0] ST_LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] ST_WAIT_TILL_EMPTY    = 4'd6;
  localparam logic [3:0] ST_CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] ST_DROP_PACKET        = 4'd8;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    LOAD_PARITY        = ST_LOAD_PARITY,
    FIFO_FULL          = ST_FIFO_FULL,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
    DROP_PACKET        = ST_DROP_PACKET
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// Control bundle between the router FSM (slave) and the register block,
// source and per-channel FIFOs (master side).
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] dest_sel;
  logic              write_enb;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              busy;
  logic              drop_pkt;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    input  dest_sel, write_enb, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy, drop_pkt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    output dest_sel, write_enb, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy, drop_pkt
  );
endinterface

// File: rtl/router_fsm_nch.sv
// N-channel packet router control FSM: latches the destination from the
// header, sequences FIFO loads, and drops invalid or starved packets.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int DATA_W       = 8,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            resetn,
  router_fsm_nch_if.slave bus
);

  localparam int ADDR_RAW   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1;
  localparam int ADDR_W     = (ADDR_RAW > DATA_W) ? DATA_W : ADDR_RAW;
  localparam int CNT_W      = (clog2(WAIT_TIMEOUT + 1) > 1) ? clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int CNT_LAST_I = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] hdr_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [NUM_CH-1:0] dest_sel_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              addr_ok;
  logic              detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q;
  logic              write_enb_q, busy_q, drop_pkt_q;

  assign hdr_addr = bus.data_in[ADDR_W-1:0];
  assign addr_ok  = ({{(32-ADDR_W){1'b0}}, hdr_addr} < NUM_CH);

  // Transitions after DECODE use only the latched destination, never live header bits.
  always_comb begin
    next_state = state;
    unique case (state)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          if (!addr_ok)                     next_state = DROP_PACKET;
          else if (bus.fifo_empty[hdr_addr]) next_state = LOAD_FIRST_DATA;
          else                              next_state = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (bus.fifo_empty[dest_addr])                   next_state = LOAD_FIRST_DATA;
        else if (WAIT_TIMEOUT != 0 && wait_cnt == CNT_LAST) next_state = DROP_PACKET;
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full[dest_addr]) next_state = FIFO_FULL;
        else if (!bus.pkt_valid)      next_state = LOAD_PARITY;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      FIFO_FULL: begin
        if (!bus.fifo_full[dest_addr]) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        next_state = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) next_state = LOAD_PARITY;
        else                        next_state = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: begin
        if (bus.fifo_full[dest_addr]) next_state = FIFO_FULL;
        else                          next_state = DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!bus.pkt_valid) next_state = DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && state != DROP_PACKET && bus.soft_reset[dest_addr])
      next_state = DECODE_ADDRESS;
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= DECODE_ADDRESS;
      detect_add_q <= 1'b1;
      lfd_q        <= 1'b0;
      ld_q         <= 1'b0;
      laf_q        <= 1'b0;
      full_q       <= 1'b0;
      rst_int_q    <= 1'b0;
      write_enb_q  <= 1'b0;
      busy_q       <= 1'b0;
      drop_pkt_q   <= 1'b0;
    end else begin
      state        <= next_state;
      detect_add_q <= (next_state == DECODE_ADDRESS);
      lfd_q        <= (next_state == LOAD_FIRST_DATA);
      ld_q         <= (next_state == LOAD_DATA);
      laf_q        <= (next_state == LOAD_AFTER_FULL);
      full_q       <= (next_state == FIFO_FULL);
      rst_int_q    <= (next_state == CHECK_PARITY_ERROR);
      write_enb_q  <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                      (next_state == LOAD_AFTER_FULL);
      busy_q       <= !((next_state == DECODE_ADDRESS) || (next_state == LOAD_DATA) ||
                        (next_state == DROP_PACKET));
      drop_pkt_q   <= (next_state == DROP_PACKET) && (state != DROP_PACKET);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || state != WAIT_TILL_EMPTY) wait_cnt <= '0;
    else                                     wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dest_addr  <= '0;
      dest_sel_q <= '0;
    end else if (state == DECODE_ADDRESS && bus.pkt_valid && addr_ok) begin
      dest_addr  <= hdr_addr;
      dest_sel_q <= {{(NUM_CH-1){1'b0}}, 1'b1} << hdr_addr;
    end
  end

  assign bus.dest_sel    = dest_sel_q;
  assign bus.write_enb   = write_enb_q;
  assign bus.detect_add  = detect_add_q;
  assign bus.lfd_state   = lfd_q;
  assign bus.ld_state    = ld_q;
  assign bus.laf_state   = laf_q;
  assign bus.full_state  = full_q;
  assign bus.rst_int_reg = rst_int_q;
  assign bus.busy        = busy_q;
  assign bus.drop_pkt    = drop_pkt_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch: a vector table on the default build plus
// hand sequences for waiting and the timeout path on a WAIT_TIMEOUT=8 build.
module tb_router_fsm_nch;

  typedef enum int { E_DEC, E_LFD, E_LD, E_LP, E_FULL, E_LAF, E_WAIT, E_CPE, E_DROP } exp_t;

  typedef struct {
    string      name;
    logic       rn;
    logic       pv;
    logic [7:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pd;
    logic       lpv;
    exp_t       st;
    logic       drop;
    logic [2:0] dest;
  } vec_t;

  logic clock;
  logic resetn;
  int   tests;
  int   fails;
  vec_t vecs[$];

  router_fsm_nch_if #(.NUM_CH(3), .DATA_W(8)) bus ();
  router_fsm_nch_if #(.NUM_CH(3), .DATA_W(8)) tbus ();

  router_fsm_nch #(.NUM_CH(3), .DATA_W(8), .WAIT_TIMEOUT(64)) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  router_fsm_nch #(.NUM_CH(3), .DATA_W(8), .WAIT_TIMEOUT(8)) dut_to (
    .clock(clock), .resetn(resetn), .bus(tbus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector order: detect, lfd, ld, laf, full, rst_int, write_enb, busy, drop.
  function automatic logic [8:0] expOut(input exp_t s, input logic drop);
    logic dec, lfd, ld, lp, full, laf, cpe, drp;
    dec  = (s == E_DEC);
    lfd  = (s == E_LFD);
    ld   = (s == E_LD);
    lp   = (s == E_LP);
    full = (s == E_FULL);
    laf  = (s == E_LAF);
    cpe  = (s == E_CPE);
    drp  = (s == E_DROP);
    return {dec, lfd, ld, laf, full, cpe, ld | lp | laf, !(dec | ld | drp), drop};
  endfunction

  function automatic logic [8:0] mainOut();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.rst_int_reg, bus.write_enb, bus.busy, bus.drop_pkt};
  endfunction

  function automatic logic [8:0] toOut();
    return {tbus.detect_add, tbus.lfd_state, tbus.ld_state, tbus.laf_state, tbus.full_state,
            tbus.rst_int_reg, tbus.write_enb, tbus.busy, tbus.drop_pkt};
  endfunction

  task automatic addVec(input string n, input logic rn, input logic pv, input logic [7:0] din,
                        input logic [2:0] full, input logic [2:0] empty, input logic [2:0] srst,
                        input logic pd, input logic lpv, input exp_t st, input logic drop,
                        input logic [2:0] dest);
    vec_t v;
    v.name = n; v.rn = rn; v.pv = pv; v.din = din; v.full = full; v.empty = empty;
    v.srst = srst; v.pd = pd; v.lpv = lpv; v.st = st; v.drop = drop; v.dest = dest;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    resetn            = v.rn;
    bus.pkt_valid     = v.pv;
    bus.data_in       = v.din;
    bus.fifo_full     = v.full;
    bus.fifo_empty    = v.empty;
    bus.soft_reset    = v.srst;
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [2:0] actDest,
                             input exp_t st, input logic drop, input logic [2:0] expDest);
    logic [8:0] want;
    want  = expOut(st, drop);
    tests = tests + 1;
    if (act !== want || actDest !== expDest) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got out=%b dest=%b, expected out=%b dest=%b",
               name, act, actDest, want, expDest);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbus.pkt_valid = 1'b0; tbus.data_in = 8'h00; tbus.fifo_full = 3'b000;
    tbus.fifo_empty = 3'b111; tbus.soft_reset = 3'b000; tbus.parity_done = 1'b0;
    tbus.low_pkt_valid = 1'b0;

    //     name          rn pv din    full    empty   srst    pd lpv  state   drop dest
    addVec("reset",      0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b000);
    addVec("np_hdr",     1, 1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 0, E_LFD,  0, 3'b010);
    addVec("np_ld1",     1, 1, 8'hA1, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("np_ld2",     1, 1, 8'hA2, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("np_ld3",     1, 1, 8'hA3, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("np_ld4",     1, 1, 8'hA4, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("np_par",     1, 0, 8'h5A, 3'b000, 3'b111, 3'b000, 0, 0, E_LP,   0, 3'b010);
    addVec("np_cpe",     1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_CPE,  0, 3'b010);
    addVec("np_dec",     1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b010);
    addVec("inv_drop",   1, 1, 8'h03, 3'b000, 3'b111, 3'b000, 0, 0, E_DROP, 1, 3'b010);
    addVec("inv_hold",   1, 1, 8'h11, 3'b000, 3'b111, 3'b000, 0, 0, E_DROP, 0, 3'b010);
    addVec("inv_dec",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b010);
    addVec("fs_hdr",     1, 1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 0, E_LFD,  0, 3'b010);
    addVec("fs_ld1",     1, 1, 8'hB1, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("fs_ld2",     1, 1, 8'hB2, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("fs_ld3",     1, 1, 8'hB3, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("fs_full1",   1, 1, 8'hB3, 3'b010, 3'b101, 3'b000, 0, 0, E_FULL, 0, 3'b010);
    addVec("fs_full2",   1, 1, 8'hB3, 3'b010, 3'b101, 3'b000, 0, 0, E_FULL, 0, 3'b010);
    addVec("fs_full3",   1, 1, 8'hB3, 3'b010, 3'b101, 3'b000, 0, 0, E_FULL, 0, 3'b010);
    addVec("fs_full4",   1, 1, 8'hB3, 3'b010, 3'b101, 3'b000, 0, 0, E_FULL, 0, 3'b010);
    addVec("fs_full5",   1, 1, 8'hB3, 3'b010, 3'b101, 3'b000, 0, 0, E_FULL, 0, 3'b010);
    addVec("fs_laf",     1, 0, 8'hB3, 3'b000, 3'b101, 3'b000, 0, 1, E_LAF,  0, 3'b010);
    addVec("fs_par",     1, 0, 8'h00, 3'b000, 3'b101, 3'b000, 0, 1, E_LP,   0, 3'b010);
    addVec("fs_cpe",     1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_CPE,  0, 3'b010);
    addVec("fs_dec",     1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b010);
    addVec("sr_hdr",     1, 1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 0, E_LFD,  0, 3'b010);
    addVec("sr_ld",      1, 1, 8'hC1, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b010);
    addVec("sr_other",   1, 1, 8'hC2, 3'b000, 3'b111, 3'b001, 0, 0, E_LD,   0, 3'b010);
    addVec("sr_abort",   1, 1, 8'hC3, 3'b000, 3'b111, 3'b010, 0, 0, E_DEC,  0, 3'b010);
    addVec("sr_idle",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b010);
    addVec("rs_hdr",     1, 1, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_LFD,  0, 3'b001);
    addVec("rs_ld",      1, 1, 8'hD1, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b001);
    addVec("rs_full1",   1, 1, 8'hD2, 3'b001, 3'b110, 3'b000, 0, 0, E_FULL, 0, 3'b001);
    addVec("rs_full2",   1, 1, 8'hD2, 3'b001, 3'b110, 3'b000, 0, 0, E_FULL, 0, 3'b001);
    addVec("rs_reset",   0, 1, 8'hD2, 3'b001, 3'b110, 3'b000, 0, 0, E_DEC,  0, 3'b000);
    addVec("rs_after",   1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b000);
    addVec("pd_hdr",     1, 1, 8'h02, 3'b000, 3'b111, 3'b000, 0, 0, E_LFD,  0, 3'b100);
    addVec("pd_ld",      1, 1, 8'hE1, 3'b000, 3'b111, 3'b000, 0, 0, E_LD,   0, 3'b100);
    addVec("pd_full",    1, 1, 8'hE2, 3'b100, 3'b011, 3'b000, 0, 0, E_FULL, 0, 3'b100);
    addVec("pd_laf",     1, 1, 8'hE2, 3'b000, 3'b011, 3'b000, 1, 1, E_LAF,  0, 3'b100);
    addVec("pd_prio",    1, 1, 8'hE2, 3'b000, 3'b011, 3'b000, 1, 1, E_DEC,  0, 3'b100);
    addVec("pd_idle",    1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, E_DEC,  0, 3'b100);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput(vecs[i].name, mainOut(), bus.dest_sel, vecs[i].st, vecs[i].drop, vecs[i].dest);
    end

    // Wait-then-go: live data_in points at an empty channel, which must be ignored.
    bus.pkt_valid = 1'b1; bus.data_in = 8'h02; bus.fifo_empty = 3'b011;
    step();
    checkOutput("wt_wait1", mainOut(), bus.dest_sel, E_WAIT, 1'b0, 3'b100);
    bus.data_in = 8'h00;
    for (int i = 2; i <= 10; i++) begin
      step();
      checkOutput($sformatf("wt_wait%0d", i), mainOut(), bus.dest_sel, E_WAIT, 1'b0, 3'b100);
    end
    bus.fifo_empty = 3'b111;
    step();
    checkOutput("wt_lfd", mainOut(), bus.dest_sel, E_LFD, 1'b0, 3'b100);
    bus.pkt_valid = 1'b0;
    step();
    checkOutput("wt_ld", mainOut(), bus.dest_sel, E_LD, 1'b0, 3'b100);
    step();
    checkOutput("wt_par", mainOut(), bus.dest_sel, E_LP, 1'b0, 3'b100);

    // Timeout on the WAIT_TIMEOUT=8 build: eight WAIT cycles, then a single drop pulse.
    tbus.pkt_valid = 1'b1; tbus.data_in = 8'h00; tbus.fifo_empty = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput($sformatf("to_wait%0d", i), toOut(), tbus.dest_sel, E_WAIT, 1'b0, 3'b001);
      tbus.data_in = 8'h01;
    end
    step();
    checkOutput("to_drop", toOut(), tbus.dest_sel, E_DROP, 1'b1, 3'b001);
    step();
    checkOutput("to_drop_hold", toOut(), tbus.dest_sel, E_DROP, 1'b0, 3'b001);
    tbus.pkt_valid = 1'b0;
    step();
    checkOutput("to_dec", toOut(), tbus.dest_sel, E_DEC, 1'b0, 3'b001);

    // Soft reset out of WAIT, then re-entry must see a fresh count.
    tbus.pkt_valid = 1'b1; tbus.data_in = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput($sformatf("to2_wait%0d", i), toOut(), tbus.dest_sel, E_WAIT, 1'b0, 3'b001);
    end
    tbus.soft_reset = 3'b001;
    step();
    checkOutput("to2_abort", toOut(), tbus.dest_sel, E_DEC, 1'b0, 3'b001);
    tbus.soft_reset = 3'b000;
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput($sformatf("to3_wait%0d", i), toOut(), tbus.dest_sel, E_WAIT, 1'b0, 3'b001);
    end
    step();
    checkOutput("to3_drop", toOut(), tbus.dest_sel, E_DROP, 1'b1, 3'b001);
    tbus.pkt_valid = 1'b0;
    step();
    checkOutput("to3_dec", toOut(), tbus.dest_sel, E_DEC, 1'b0, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
